counter_input_conditioner: RTL

//  Upstream stage of the digital counter. Turns two raw, bouncy push-button inputs (up/down) into

---
 rtl/counter_input_conditioner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/counter_input_conditioner.sv
// Conditions the raw up/down buttons into clean, mutually exclusive step pulses for the counter core.
// Each channel has a two-flop synchroniser, a debounce FSM and optional hold-to-repeat.

module counter_input_conditioner_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int TW              = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic s,
  input  logic repeat_en,
  output logic req,
  output logic held
);
  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;

  localparam logic [TW-1:0] DB_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RR_LOAD = TW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] ONE     = TW'(1);

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic          req_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      req   <= req_next;
    end
  end

  // The timer counts up while debouncing and down (to zero) between repeats while held.
  always_comb begin
    state_next = state;
    timer_next = timer;
    if (!ena) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            state_next = ARMING;
            timer_next = ONE;
          end else begin
            timer_next = '0;
          end
        end
        ARMING: begin
          if (!s) begin
            state_next = IDLE;
            timer_next = '0;
          end else if (timer == DB_LAST) begin
            state_next = HELD;
            timer_next = RD_LOAD;
          end else begin
            timer_next = timer + ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state_next = RELEASING;
            timer_next = ONE;
          end else if (!repeat_en) begin
            timer_next = RD_LOAD;
          end else if (timer == '0) begin
            timer_next = RR_LOAD;
          end else begin
            timer_next = timer - ONE;
          end
        end
        RELEASING: begin
          if (s) begin
            state_next = HELD;
            timer_next = RR_LOAD;
          end else if (timer == DB_LAST) begin
            state_next = IDLE;
            timer_next = '0;
          end else begin
            timer_next = timer + ONE;
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    req_next = 1'b0;
    held     = (state == HELD) || (state == RELEASING);
    if (ena) begin
      case (state)
        ARMING:  req_next = s && (timer == DB_LAST);
        HELD:    req_next = s && repeat_en && (timer == '0);
        default: req_next = 1'b0;
      endcase
    end
  end
endmodule

module counter_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  input  logic repeat_en,
  output logic step_up,
  output logic step_dn,
  output logic up_held,
  output logic dn_held
);
  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int TW     = $clog2(MAX_P) + 1;

  logic [1:0] up_sync, dn_sync;
  logic       req_up, req_dn, held_up, held_dn;

  // Synchronisers keep running while ena is low so a re-enable sees settled levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], btn_up_raw};
      dn_sync <= {dn_sync[0], btn_dn_raw};
    end
  end

  counter_input_conditioner_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .TW(TW)
  ) u_up (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s(up_sync[1]),
    .repeat_en(repeat_en), .req(req_up), .held(held_up)
  );

  counter_input_conditioner_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .TW(TW)
  ) u_dn (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s(dn_sync[1]),
    .repeat_en(repeat_en), .req(req_dn), .held(held_dn)
  );

  // Coinciding requests cancel each other so the counter never sees both directions at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      up_held <= 1'b0;
      dn_held <= 1'b0;
    end else if (!ena) begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      up_held <= 1'b0;
      dn_held <= 1'b0;
    end else begin
      step_up <= req_up & ~req_dn;
      step_dn <= req_dn & ~req_up;
      up_held <= held_up;
      dn_held <= held_dn;
    end
  end
endmodule
